divider_8_bit: RTL and testbench

Sequential shift-subtract (restoring) divider. It is the inverse companion of the shift-add multiplier datapath: operands come from switch-side registers, one quotient bit is resolved per clock, and quotient and remainder are presented on registered outputs. The block owns its own control FSM and is started with a single-cycle `start` handshake that completes with a `done` pulse.

---
 rtl/divider_8_bit_if.sv | 25 ++
 rtl/divider_8_bit.sv | 165 ++++++++++++++++
 tb/tb_divider_8_bit.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/divider_8_bit_if.sv
// Request/result bundle for the restoring divider: operands and start in, results and status out.
interface divider_8_bit_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, signed_mode, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero, overflow
    );

    modport slave (
        input  start, signed_mode, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero, overflow
    );
endinterface

// File: rtl/divider_8_bit.sv
// Sequential restoring divider: one quotient bit per clock, sign fix-up, registered results.
module divider_8_bit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    divider_8_bit_if.slave bus
);
    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t           state, state_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [WIDTH-1:0] r, r_d;
    logic [WIDTH-1:0] q, q_d;
    logic [WIDTH-1:0] dsr, dsr_d;
    logic             q_neg, q_neg_d;
    logic             r_neg, r_neg_d;
    logic             ovf_pend, ovf_pend_d;
    logic             dbz_pend, dbz_pend_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic             a_neg;
    logic             b_neg;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            r           <= '0;
            q           <= '0;
            dsr         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            ovf_pend    <= 1'b0;
            dbz_pend    <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            r           <= r_d;
            q           <= q_d;
            dsr         <= dsr_d;
            q_neg       <= q_neg_d;
            r_neg       <= r_neg_d;
            ovf_pend    <= ovf_pend_d;
            dbz_pend    <= dbz_pend_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

    // Next-state, iteration step and result write-back
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        r_d         = r;
        q_d         = q;
        dsr_d       = dsr;
        q_neg_d     = q_neg;
        r_neg_d     = r_neg;
        ovf_pend_d  = ovf_pend;
        dbz_pend_d  = dbz_pend;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;

        a_neg = bus.signed_mode & bus.dividend[WIDTH-1];
        b_neg = bus.signed_mode & bus.divisor[WIDTH-1];
        a_abs = a_neg ? WIDTH'(-bus.dividend) : bus.dividend;
        b_abs = b_neg ? WIDTH'(-bus.divisor) : bus.divisor;
        r_sh  = {r, q[WIDTH-1]};
        trial = r_sh - {1'b0, dsr};

        case (state)
            IDLE: begin
                if (bus.start) begin
                    cnt_d      = '0;
                    r_d        = '0;
                    q_neg_d    = a_neg ^ b_neg;
                    r_neg_d    = a_neg;
                    ovf_pend_d = bus.signed_mode
                               && (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}})
                               && (bus.divisor == '1);
                    // Divide-by-zero still passes through FIX so done lands one cycle after start
                    if (bus.divisor == '0) begin
                        dbz_pend_d = 1'b1;
                        q_d        = bus.dividend;
                        dsr_d      = '0;
                        state_d    = FIX;
                    end else begin
                        dbz_pend_d = 1'b0;
                        q_d        = a_abs;
                        dsr_d      = b_abs;
                        state_d    = ITER;
                    end
                end
            end
            ITER: begin
                if (r_sh >= {1'b0, dsr}) begin
                    r_d = trial[WIDTH-1:0];
                    q_d = {q[WIDTH-2:0], 1'b1};
                end else begin
                    r_d = r_sh[WIDTH-1:0];
                    q_d = {q[WIDTH-2:0], 1'b0};
                end
                cnt_d = CW'(cnt + 1'b1);
                if (cnt == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (dbz_pend) begin
                    quotient_d  = '1;
                    remainder_d = q;
                    dbz_d       = 1'b1;
                    ovf_d       = 1'b0;
                end else begin
                    quotient_d  = q_neg ? WIDTH'(-q) : q;
                    remainder_d = r_neg ? WIDTH'(-r) : r;
                    dbz_d       = 1'b0;
                    ovf_d       = ovf_pend;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == ITER) || (state_d == FIX);
        done_d = (state_d == DONE);
    end

    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_divider_8_bit.sv
// Self-checking bench for divider_8_bit: directed vectors, handshake/abort sequences, random vs. arithmetic model.
module tb_divider_8_bit;
    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    divider_8_bit_if #(.WIDTH(W)) bus ();
    divider_8_bit #(.WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       sm;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        logic       ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division, which truncates toward zero with remainder signed like the dividend
    function automatic vec_t model(input logic sm, input logic [7:0] a, input logic [7:0] b);
        vec_t v;
        int sa, sb;
        v.sm = sm; v.a = a; v.b = b; v.dbz = 1'b0; v.ovf = 1'b0;
        if (b == 8'd0) begin
            v.q = 8'hFF; v.r = a; v.dbz = 1'b1;
        end else begin
            sa = sm ? int'($signed(a)) : int'(a);
            sb = sm ? int'($signed(b)) : int'(b);
            v.q = 8'(sa / sb);
            v.r = 8'(sa % sb);
            v.ovf = sm && (sa == -128) && (sb == -1);
        end
        return v;
    endfunction

    function automatic logic [19:0] outs();
        return {bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero, bus.overflow};
    endfunction

    task automatic run_op(input vec_t v, input string tag);
        int  lat;
        bit  seen;
        @(negedge clk);
        bus.start = 1'b1; bus.signed_mode = v.sm; bus.dividend = v.a; bus.divisor = v.b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.dividend = 8'($urandom); bus.divisor = 8'($urandom); bus.signed_mode = 1'($urandom);
        chk({tag, " busy_at_start"}, 32'(bus.busy), 32'd1);
        lat = 0; seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            lat++;
            chk({tag, " busy_and_done"}, 32'(bus.busy & bus.done), 32'd0);
            if (bus.done) seen = 1;
        end
        chk({tag, " latency"}, 32'(lat), (v.b == 8'd0) ? 32'd1 : 32'd9);
        chk({tag, " quotient"}, 32'(bus.quotient), 32'(v.q));
        chk({tag, " remainder"}, 32'(bus.remainder), 32'(v.r));
        chk({tag, " div_by_zero"}, 32'(bus.div_by_zero), 32'(v.dbz));
        chk({tag, " overflow"}, 32'(bus.overflow), 32'(v.ovf));
        @(posedge clk); #1;
        chk({tag, " done_one_cycle"}, 32'({bus.done, bus.busy}), 32'd0);
        chk({tag, " result_held"}, 32'({bus.quotient, bus.remainder}), 32'({v.q, v.r}));
    endtask

    vec_t        vecs[11];
    vec_t        v;
    logic [19:0] acc;
    int          ndone;
    logic [7:0]  cap_q, cap_r;

    initial begin
        vecs[0]  = '{1'b0, 8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 1'b0};
        vecs[1]  = '{1'b0, 8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 1'b0};
        vecs[2]  = '{1'b1, 8'hF9,  8'h02,  8'hFD,  8'hFF,  1'b0, 1'b0};
        vecs[3]  = '{1'b1, 8'h07,  8'hFE,  8'hFD,  8'h01,  1'b0, 1'b0};
        vecs[4]  = '{1'b1, 8'h80,  8'hFF,  8'h80,  8'h00,  1'b0, 1'b1};
        vecs[5]  = '{1'b0, 8'h2A,  8'h00,  8'hFF,  8'h2A,  1'b1, 1'b0};
        vecs[6]  = '{1'b0, 8'd7,   8'd10,  8'd0,   8'd7,   1'b0, 1'b0};
        vecs[7]  = '{1'b1, 8'h80,  8'h01,  8'h80,  8'h00,  1'b0, 1'b0};
        vecs[8]  = '{1'b0, 8'hFF,  8'hFF,  8'h01,  8'h00,  1'b0, 1'b0};
        vecs[9]  = '{1'b1, 8'h81,  8'h7F,  8'hFF,  8'h00,  1'b0, 1'b0};
        vecs[10] = '{1'b1, 8'h85,  8'hF9,  8'h11,  8'hFC,  1'b0, 1'b0};

        bus.start = 1'b0; bus.signed_mode = 1'b0; bus.dividend = '0; bus.divisor = '0;

        // Reset and idle quiescence
        repeat (3) @(posedge clk);
        #1 chk("reset_outputs", 32'(outs()), 32'd0);
        @(negedge clk) reset_n = 1'b1;
        acc = '0;
        repeat (20) begin
            @(posedge clk); #1;
            acc |= outs();
        end
        chk("idle_outputs", 32'(acc), 32'd0);

        foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

        // Second start three cycles into a busy operation must be ignored
        @(negedge clk);
        bus.start = 1'b1; bus.signed_mode = 1'b0; bus.dividend = 8'd100; bus.divisor = 8'd7;
        @(negedge clk); bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 8'd3;
        @(negedge clk); bus.start = 1'b0;
        ndone = 0; cap_q = '0; cap_r = '0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.done) begin
                ndone++; cap_q = bus.quotient; cap_r = bus.remainder;
            end
        end
        chk("hs_done_count", 32'(ndone), 32'd1);
        chk("hs_quotient", 32'(cap_q), 32'd14);
        chk("hs_remainder", 32'(cap_r), 32'd2);

        // Asynchronous abort in the middle of iterating
        @(negedge clk);
        bus.start = 1'b1; bus.signed_mode = 1'b0; bus.dividend = 8'd250; bus.divisor = 8'd3;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset_n = 1'b0;
        #1 chk("abort_outputs", 32'(outs()), 32'd0);
        @(negedge clk) reset_n = 1'b1;
        ndone = 0; acc = '0;
        repeat (12) begin
            @(posedge clk); #1;
            acc |= outs();
        end
        chk("abort_no_done", 32'(acc), 32'd0);
        run_op(model(1'b0, 8'd200, 8'd3), "post_abort");

        // Randomized operations against the arithmetic model
        for (int n = 0; n < 150; n++) begin
            logic       sm;
            logic [7:0] a, b;
            sm = 1'($urandom);
            a  = ($urandom_range(0, 9) == 0) ? 8'h80 : 8'($urandom);
            case ($urandom_range(0, 11))
                0:       b = 8'h00;
                1:       b = 8'hFF;
                2:       b = 8'h01;
                default: b = 8'($urandom);
            endcase
            v = model(sm, a, b);
            run_op(v, $sformatf("rnd%0d sm=%0d %0h/%0h", n, sm, a, b));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
